read_burst_arbiter: RTL and testbench

- Shares one AXI read command/data path among NREQ read-FIFO requesters, e.g. one per video plane or stream.
- Each requester holds a level burst/tail request with a length. The arbiter grants requesters round-robin and issues one command downstream.
- It returns a one-cycle resp pulse when the command is accepted and a one-cycle done pulse when the last read beat arrives.
- Only one burst is outstanding at a time. Sits between the per-stream FIFO status controllers and the AXI read master.

---
 rtl/read_vdma_pkg.sv | 15 +
 rtl/read_burst_arbiter_rr_pick.sv | 26 ++
 rtl/read_burst_arbiter.sv | 127 ++++++++++++
 tb/tb_read_burst_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_vdma_pkg.sv
// read_vdma_pkg: shared FSM states, sizing helper and default burst-length width for the read VDMA path
package read_vdma_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA, FIN} state_e;

    localparam int LSIZE_DEF = 9;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/read_burst_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first pending index after ptr with wrap
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] pending_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            any_o,
    output logic [IDW-1:0]  idx_o,
    output logic [NREQ-1:0] onehot_o
);

    // scan from farthest to nearest so the nearest pending index after ptr is the last one written
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (pending_i[(int'(ptr_i) + k) % NREQ]) begin
                any_o = 1'b1;
                idx_o = IDW'((int'(ptr_i) + k) % NREQ);
            end
        end
        onehot_o = any_o ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/read_burst_arbiter.sv
// read_burst_arbiter: round-robin sharing of one AXI read command/data path, one burst in flight
module read_burst_arbiter
    import read_vdma_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LSIZE = LSIZE_DEF,
    parameter int IDW   = clog2(NREQ)
) (
    input  logic                  clock_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [NREQ-1:0]       req_burst_i,
    input  logic [NREQ-1:0]       req_tail_i,
    input  logic [NREQ*LSIZE-1:0] req_len_i,
    output logic [NREQ-1:0]       resp_o,
    output logic [NREQ-1:0]       done_o,
    output logic [NREQ-1:0]       grant_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [LSIZE-1:0]      cmd_len_o,
    output logic                  cmd_tail_o,
    output logic [IDW-1:0]        cmd_id_o,
    input  logic                  rd_beat_i,
    input  logic                  rd_last_i,
    output logic                  len_err_o,
    input  logic                  err_clr_i
);

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d, id_q, id_d;
    logic [LSIZE-1:0]  len_q, len_d, cnt_q, cnt_d, cnt_inc, win_len;
    logic              tail_q, tail_d, valid_q, valid_d, err_q, err_d, err_set, any;
    logic [NREQ-1:0]   grant_q, grant_d, resp_q, resp_d, win_oh;
    logic [IDW-1:0]    win_idx;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .pending_i(req_burst_i | req_tail_i),
        .ptr_i    (ptr_q),
        .any_o    (any),
        .idx_o    (win_idx),
        .onehot_o (win_oh)
    );

    assign win_len     = req_len_i[int'(win_idx)*LSIZE +: LSIZE];
    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign resp_o      = resp_q;
    assign done_o      = (state_q == FIN) ? grant_q : '0;
    assign grant_o     = grant_q;
    assign cmd_valid_o = valid_q;
    assign cmd_len_o   = len_q;
    assign cmd_tail_o  = tail_q;
    assign cmd_id_o    = id_q;
    assign len_err_o   = err_q;

    // state and datapath registers, all cleared by reset; pointer starts at NREQ-1 so requester 0 wins first
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            len_q   <= '0;
            tail_q  <= 1'b0;
            cnt_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            resp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    // next-state: grant in IDLE, wait for handshake in CMD, count beats in DATA, pulse done in FIN
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        len_d   = len_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        valid_d = valid_q;
        resp_d  = '0;
        err_set = rd_beat_i && (state_q != DATA);
        case (state_q)
            IDLE: if (enable_i && any) begin
                id_d    = win_idx;
                len_d   = win_len;
                tail_d  = req_tail_i[win_idx];
                grant_d = win_oh;
                valid_d = (win_len != '0);
                resp_d  = (win_len == '0) ? win_oh : '0;
                state_d = (win_len == '0) ? FIN : CMD;
            end
            CMD: if (cmd_ready_i) begin
                valid_d = 1'b0;
                resp_d  = grant_q;
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: if (rd_beat_i) begin
                cnt_d = cnt_inc;
                if (rd_last_i) begin
                    err_set = (cnt_inc != len_q);
                    state_d = FIN;
                end
            end
            FIN: begin
                grant_d = '0;
                ptr_d   = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_d = (err_q & ~err_clr_i) | err_set;
    end

endmodule

// File: tb/tb_read_burst_arbiter.sv
// tb_read_burst_arbiter: scenario tasks with a command scoreboard for read_burst_arbiter
module tb_read_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst, en, cr, beat, last, eclr;
    logic [1:0]  rb, rt;
    logic [17:0] rl;
    logic [1:0]  resp, done, grant;
    logic        cv, ctail, cid, err;
    logic [8:0]  clen;

    typedef struct {
        logic       id;
        logic [8:0] len;
        logic       tail;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    read_burst_arbiter #(.NREQ(2), .LSIZE(9), .IDW(1)) dut (
        .clock_i    (clk),
        .rst_i      (rst),
        .enable_i   (en),
        .req_burst_i(rb),
        .req_tail_i (rt),
        .req_len_i  (rl),
        .resp_o     (resp),
        .done_o     (done),
        .grant_o    (grant),
        .cmd_valid_o(cv),
        .cmd_ready_i(cr),
        .cmd_len_o  (clen),
        .cmd_tail_o (ctail),
        .cmd_id_o   (cid),
        .rd_beat_i  (beat),
        .rd_last_i  (last),
        .len_err_o  (err),
        .err_clr_i  (eclr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard: every accepted command is popped and compared; exclusivity checked every cycle
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(grant) > 1 || $countones(resp) > 1 || $countones(done) > 1) begin
                fails++;
                $display("FAIL onehot: grant=%b resp=%b done=%b, at most one bit required", grant, resp, done);
            end
            if (cv && cr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL cmd_unexpected: id=%0d len=%0d tail=%0d, no command expected", cid, clen, ctail);
                end else begin
                    cmd_t e;
                    e = exp_q.pop_front();
                    if (cid !== e.id || clen !== e.len || ctail !== e.tail) begin
                        fails++;
                        $display("FAIL cmd: id=%0d len=%0d tail=%0d, required id=%0d len=%0d tail=%0d",
                                 cid, clen, ctail, e.id, e.len, e.tail);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input int n, input int last_at);
        for (int i = 1; i <= n; i++) begin
            beat = 1'b1;
            last = (i == last_at);
            tick();
        end
        beat = 1'b0;
        last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cr = 1'b0; beat = 1'b0; last = 1'b0; eclr = 1'b0;
        rb = 2'b00; rt = 2'b00; rl = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({resp, done, grant, cv, clen, ctail, cid, err} !== '0) begin
            fails++;
            $display("FAIL reset: resp=%b done=%b grant=%b cv=%b len=%0d tail=%b id=%b err=%b, all 0 required",
                     resp, done, grant, cv, clen, ctail, cid, err);
        end
        tick();
        checks++;
        if (cv !== 1'b0 || grant !== 2'b00) begin
            fails++;
            $display("FAIL idle_no_req: cv=%b grant=%b, 0/00 required", cv, grant);
        end
    endtask

    task automatic test_single_burst();
        rb = 2'b01;
        rl = {9'd0, 9'd200};
        exp_q.push_back('{id: 1'b0, len: 9'd200, tail: 1'b0});
        tick();
        rb = 2'b00;
        checks++;
        if (cv !== 1'b1 || grant !== 2'b01 || clen !== 9'd200 || ctail !== 1'b0 || cid !== 1'b0) begin
            fails++;
            $display("FAIL single_issue: cv=%b grant=%b len=%0d tail=%b id=%b, required 1 01 200 0 0",
                     cv, grant, clen, ctail, cid);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (cv !== 1'b1 || grant !== 2'b01 || resp !== 2'b00) begin
            fails++;
            $display("FAIL single_hold: cv=%b grant=%b resp=%b, required 1 01 00", cv, grant, resp);
        end
        cr = 1'b1;
        tick();
        cr = 1'b0;
        checks++;
        if (resp !== 2'b01 || cv !== 1'b0) begin
            fails++;
            $display("FAIL single_resp: resp=%b cv=%b, required 01 0", resp, cv);
        end
        tick();
        checks++;
        if (resp !== 2'b00) begin
            fails++;
            $display("FAIL single_resp_width: resp=%b, required 00", resp);
        end
        beats(200, 200);
        checks++;
        if (done !== 2'b01 || grant !== 2'b01 || err !== 1'b0) begin
            fails++;
            $display("FAIL single_done: done=%b grant=%b err=%b, required 01 01 0", done, grant, err);
        end
        tick();
        checks++;
        if (done !== 2'b00 || grant !== 2'b00) begin
            fails++;
            $display("FAIL single_release: done=%b grant=%b, required 00 00", done, grant);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] oh;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rb = 2'b11;
        rl = {9'd4, 9'd4};
        cr = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back('{id: 1'(k % 2), len: 9'd4, tail: 1'b0});
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checks++;
            if (grant !== oh || cv !== 1'b1) begin
                fails++;
                $display("FAIL rr_grant%0d: grant=%b cv=%b, required %b 1", k, grant, cv, oh);
            end
            tick();
            checks++;
            if (resp !== oh) begin
                fails++;
                $display("FAIL rr_resp%0d: resp=%b, required %b", k, resp, oh);
            end
            beats(4, 4);
            checks++;
            if (done !== oh) begin
                fails++;
                $display("FAIL rr_done%0d: done=%b, required %b", k, done, oh);
            end
            if (k == 3) rb = 2'b00;
            tick();
            checks++;
            if (grant !== 2'b00 || cv !== 1'b0) begin
                fails++;
                $display("FAIL rr_gap%0d: grant=%b cv=%b, required 00 0", k, grant, cv);
            end
        end
        cr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL rr_err: len_err=%b, required 0", err);
        end
    endtask

    task automatic test_tail_zero();
        rb = 2'b10;
        rt = 2'b10;
        rl = {9'd37, 9'd0};
        exp_q.push_back('{id: 1'b1, len: 9'd37, tail: 1'b1});
        tick();
        rb = 2'b00;
        rt = 2'b00;
        checks++;
        if (cv !== 1'b1 || ctail !== 1'b1 || clen !== 9'd37 || cid !== 1'b1) begin
            fails++;
            $display("FAIL tail_issue: cv=%b tail=%b len=%0d id=%b, required 1 1 37 1", cv, ctail, clen, cid);
        end
        cr = 1'b1;
        tick();
        cr = 1'b0;
        beats(37, 37);
        checks++;
        if (done !== 2'b10 || err !== 1'b0) begin
            fails++;
            $display("FAIL tail_done: done=%b err=%b, required 10 0", done, err);
        end
        tick();
        rb = 2'b01;
        rl = {9'd37, 9'd0};
        tick();
        rb = 2'b00;
        checks++;
        if (resp !== 2'b01 || done !== 2'b01 || cv !== 1'b0 || grant !== 2'b01) begin
            fails++;
            $display("FAIL zero_len: resp=%b done=%b cv=%b grant=%b, required 01 01 0 01", resp, done, cv, grant);
        end
        tick();
        checks++;
        if (resp !== 2'b00 || done !== 2'b00 || grant !== 2'b00 || cv !== 1'b0) begin
            fails++;
            $display("FAIL zero_after: resp=%b done=%b grant=%b cv=%b, required 00 00 00 0", resp, done, grant, cv);
        end
    endtask

    task automatic test_len_err();
        rb = 2'b01;
        rl = {9'd0, 9'd8};
        exp_q.push_back('{id: 1'b0, len: 9'd8, tail: 1'b0});
        tick();
        rb = 2'b00;
        cr = 1'b1;
        tick();
        cr = 1'b0;
        beats(6, 6);
        checks++;
        if (done !== 2'b01 || err !== 1'b1) begin
            fails++;
            $display("FAIL short_burst: done=%b err=%b, required 01 1", done, err);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: len_err=%b, required 1", err);
        end
        beat = 1'b1;
        eclr = 1'b1;
        tick();
        beat = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_set_wins: len_err=%b, required 1", err);
        end
        tick();
        eclr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: len_err=%b, required 0", err);
        end
        beat = 1'b1;
        tick();
        beat = 1'b0;
        checks++;
        if (err !== 1'b1 || grant !== 2'b00) begin
            fails++;
            $display("FAIL stray_beat: len_err=%b grant=%b, required 1 00", err, grant);
        end
        eclr = 1'b1;
        tick();
        eclr = 1'b0;
    endtask

    task automatic test_enable_reset();
        rb = 2'b01;
        rl = {9'd3, 9'd3};
        exp_q.push_back('{id: 1'b0, len: 9'd3, tail: 1'b0});
        tick();
        cr = 1'b1;
        tick();
        cr = 1'b0;
        en = 1'b0;
        beats(3, 3);
        checks++;
        if (done !== 2'b01 || err !== 1'b0) begin
            fails++;
            $display("FAIL en_low_done: done=%b err=%b, required 01 0", done, err);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (grant !== 2'b00 || cv !== 1'b0) begin
                fails++;
                $display("FAIL en_low_hold%0d: grant=%b cv=%b, required 00 0", i, grant, cv);
            end
        end
        en = 1'b1;
        rb = 2'b11;
        tick();
        checks++;
        if (grant !== 2'b10 || cv !== 1'b1) begin
            fails++;
            $display("FAIL rr_after_en: grant=%b cv=%b, required 10 1", grant, cv);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (cv !== 1'b0 || grant !== 2'b00) begin
            fails++;
            $display("FAIL rst_in_cmd: cv=%b grant=%b, required 0 00", cv, grant);
        end
        exp_q.push_back('{id: 1'b0, len: 9'd3, tail: 1'b0});
        tick();
        rb = 2'b00;
        checks++;
        if (grant !== 2'b01 || cid !== 1'b0) begin
            fails++;
            $display("FAIL grant_after_rst: grant=%b id=%b, required 01 0", grant, cid);
        end
        cr = 1'b1;
        tick();
        cr = 1'b0;
        beats(3, 3);
        checks++;
        if (done !== 2'b01) begin
            fails++;
            $display("FAIL post_rst_done: done=%b, required 01", done);
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d commands outstanding, 0 required", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_tail_zero();
        test_len_err();
        test_enable_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
